nibbler_button_port: RTL
========================

NIBBLER_BUTTON_PORT -- requirements
Module: nibbler_button_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles required to accept a new level; legal range 1..255.
REQ-002 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-003 notReset  input  1  reset, synchronous and active-low.
REQ-004 btn_raw  input  4  raw mechanical buttons, asynchronous, active-low (0 = pressed), may bounce.
REQ-005 rd_strobe  input  1  high for exactly the one clk_in cycle in which the CPU samples pushbuttons (IN instruction); acknowledges latched presses.
REQ-006 pushbuttons  output  4  conditioned button value presented to the CPU data-bus input mux, active-low (0 = pressed).
REQ-007 press_pending  output  1  high while any latched, unacknowledged press exists.
REQ-008 btn_level  output  4  debounced level per button, active-high (1 = held), for debug and LEDs.

Function
REQ-009 Each btn_raw bit shall pass through a two-flop synchronizer before any other logic.
REQ-010 Each bit shall have an 8-bit stability counter; it increments while the synchronized value differs from the debounced value and clears to 0 on the first cycle they agree.
REQ-011 When a differing synchronized value persists for DEBOUNCE_CYCLES consecutive cycles, the debounced value shall take it on the next edge and the counter shall clear.
REQ-012 Latency shall be exactly DEBOUNCE_CYCLES+2 rising edges from the first edge that samples a new stable btn_raw value to the change on btn_level.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no change on btn_level, pushbuttons or press_pending.
REQ-014 A press event is a debounced 0->1 transition of btn_level[i]; a release event is its 1->0 transition.
REQ-015 Counters shall saturate and never wrap; bits are independent, and simultaneous events on several bits shall all be honoured in the same cycle.
REQ-016 pushbuttons, btn_level and press_pending shall be registered outputs, glitch-free, with no combinational path from btn_raw or rd_strobe.

Reset
REQ-017 While notReset is low at a rising edge: synchronizer flops shall load 1 (released), counters and latches 0, btn_level 4'b0000, pushbuttons 4'b1111, press_pending 0.
REQ-018 Reset asserted mid-debounce shall discard all partial counts; no event shall be generated from pre-reset activity.
REQ-019 After notReset rises, a button already held shall be reported as a fresh press after the REQ-012 latency.

Configuration
REQ-020 Macro NIBBLER_BTN_STICKY_EN defined: a 4-bit press latch shall set on a press event and clear on a rd_strobe cycle; pushbuttons[i] = ~(latch[i] | btn_level[i]); press_pending = |latch.
REQ-021 With NIBBLER_BTN_STICKY_EN, a press event coinciding with rd_strobe on the same bit shall leave that latch set (set wins).
REQ-022 With NIBBLER_BTN_STICKY_EN, a release before the CPU reads shall not clear the latch; the press is still reported once.
REQ-023 Macro undefined: no latch is built; pushbuttons = ~btn_level; press_pending is tied 0; rd_strobe is ignored.

Structure
REQ-024 Package nibbler_pkg shall hold NIB_W = 4, the typedef nibble_t (logic [3:0]), and BTN_RELEASED = 4'b1111.
REQ-025 One sub-module, nibbler_btn_debounce, shall implement REQ-009 to REQ-011 for one bit; it shall be instantiated NIB_W times.
REQ-026 The press latch, output registers and macro logic shall reside in the top module.

Verification
REQ-027 Reset with btn_raw = 4'b1111 -> pushbuttons = 4'b1111, btn_level = 0, press_pending = 0 on the first edge with notReset low.
REQ-028 DEBOUNCE_CYCLES = 4; btn_raw[0] driven to 0 and held -> btn_level = 4'b0001 and pushbuttons = 4'b1110 exactly 6 edges later.
REQ-029 btn_raw[2] bounces 0,1,0,1 at 1-cycle spacing, then settles at 0 -> no output change during the bounce; btn_level[2] = 1 exactly 6 edges after the last transition.
REQ-030 STICKY: press and release btn_raw[1] (held 10 cycles), no rd_strobe -> pushbuttons = 4'b1101 and press_pending = 1 persist; one rd_strobe -> pushbuttons = 4'b1111 and press_pending = 0 on the next edge.
REQ-031 STICKY: the press event on bit 3 lands in the same cycle as rd_strobe -> latch[3] stays set and press_pending remains 1.
REQ-032 notReset pulsed low while counter[0] = 2 -> counter cleared, no press event generated; a held button is reported 6 edges after reset release.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler pushbutton port.
// Nibble width, nibble type and the all-released button pattern.
package nibbler_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nibble_t;

  localparam nibble_t BTN_RELEASED = 4'b1111;

endpackage

// File: rtl/nibbler_btn_debounce.sv
// One-bit synchronizer and debouncer for an active-low pushbutton.
// level is active-high; level_nxt is its next value, from flop state only.
module nibbler_btn_debounce
  import nibbler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_in,
  input  logic notReset,
  input  logic btn_raw,
  output logic level,
  output logic level_nxt
);

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       differ;

  // raw is active-low, level active-high: equal bits mean disagreement
  assign differ = (sync2 == level);

  always_comb begin
    level_nxt = level;
    cnt_nxt   = cnt;
    if (!differ) begin
      cnt_nxt = 8'd0;
    end else if (cnt >= LIMIT) begin
      level_nxt = ~level;
      cnt_nxt   = 8'd0;
    end else if (cnt != 8'hff) begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!notReset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= 8'd0;
      level <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end

endmodule

// File: rtl/nibbler_button_port.sv
// Nibbler CPU pushbutton port: per-bit debounce plus registered outputs.
// Define NIBBLER_BTN_STICKY_EN to latch presses until the CPU reads them.
module nibbler_button_port
  import nibbler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_in,
  input  logic       notReset,
  input  logic [3:0] btn_raw,
  input  logic       rd_strobe,
  output logic [3:0] pushbuttons,
  output logic       press_pending,
  output logic [3:0] btn_level
);

  nibble_t level_w;
  nibble_t level_nxt;
  nibble_t pb_d;
  logic    pend_d;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    nibbler_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_in    (clk_in),
      .notReset  (notReset),
      .btn_raw   (btn_raw[i]),
      .level     (level_w[i]),
      .level_nxt (level_nxt[i])
    );
  end

  assign btn_level = level_w;

`ifdef NIBBLER_BTN_STICKY_EN
  nibble_t latch_q;
  nibble_t latch_d;
  nibble_t press;

  // set beats clear when a press lands on a read cycle
  assign press   = level_nxt & ~level_w;
  assign latch_d = (latch_q & ~{NIB_W{rd_strobe}}) | press;
  assign pb_d    = ~(latch_d | level_nxt);
  assign pend_d  = |latch_d;

  always_ff @(posedge clk_in) begin
    if (!notReset) latch_q <= '0;
    else           latch_q <= latch_d;
  end
`else
  logic unused_rd;

  assign unused_rd = rd_strobe;
  assign pb_d      = ~level_nxt;
  assign pend_d    = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!notReset) begin
      pushbuttons   <= BTN_RELEASED;
      press_pending <= 1'b0;
    end else begin
      pushbuttons   <= pb_d;
      press_pending <= pend_d;
    end
  end

endmodule
